// File: rtl/burst_mem_responder.sv
// Responder end of the 64-bit pmem burst interface. It moves a 256-bit line
// as four 64-bit beats to or from an internal line array after a fixed delay.
module burst_mem_responder #(
  parameter int unsigned LINE_IDX_W = 8,
  parameter int unsigned DELAY      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        protocol_err
);

  localparam int unsigned LINES      = 1 << LINE_IDX_W;
  localparam logic [7:0]  DELAY_INIT = 8'(DELAY);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t                  state;
  logic [7:0]              delay_cnt;
  logic [1:0]              beat;
  logic [LINE_IDX_W-1:0]   line_idx;
  logic                    op_write;
  logic [63:0]             mem [LINES][4];

  logic [LINE_IDX_W-1:0]   req_idx;
  logic                    req_bad;
  logic                    unused_addr_bits;

  assign req_idx          = pmem_address[LINE_IDX_W+4:5];
  assign unused_addr_bits = ^{pmem_address[31:LINE_IDX_W+5], pmem_address[4:0]};

  // Latched request dropped, or the opposite request raised, while in flight.
  assign req_bad = op_write ? (!pmem_write || pmem_read)
                            : (!pmem_read  || pmem_write);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      pmem_resp    <= 1'b0;
      pmem_rdata   <= '0;
      protocol_err <= 1'b0;
      delay_cnt    <= '0;
      beat         <= '0;
      line_idx     <= '0;
      op_write     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_read && pmem_write) begin
            protocol_err <= 1'b1;
          end else if (pmem_read || pmem_write) begin
            line_idx  <= req_idx;
            op_write  <= pmem_write;
            delay_cnt <= DELAY_INIT;
            beat      <= '0;
            if (DELAY == 0) begin
              state      <= BURST;
              pmem_resp  <= 1'b1;
              pmem_rdata <= pmem_write ? '0 : mem[req_idx][0];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (req_bad) protocol_err <= 1'b1;
          delay_cnt <= delay_cnt - 8'd1;
          if (delay_cnt == 8'd1) begin
            state      <= BURST;
            pmem_resp  <= 1'b1;
            pmem_rdata <= op_write ? '0 : mem[line_idx][0];
          end
        end
        BURST: begin
          if (req_bad) protocol_err <= 1'b1;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state      <= DONE;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
          end else begin
            pmem_rdata <= op_write ? '0 : mem[line_idx][beat + 2'd1];
          end
        end
        DONE: begin
          state <= IDLE;
          beat  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never reset; a reset edge suppresses the pending beat write.
  always_ff @(posedge clk) begin
    if (reset_n && state == BURST && op_write)
      mem[line_idx][beat] <= pmem_wdata;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: two instances (DELAY=4 and DELAY=0) checked
// against a line-level memory model with per-cycle timing expectations.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic        resp  [2];
  logic        err   [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [255:0] model   [2][256];
  bit           known   [2][256];
  bit           errflag [2];

  burst_mem_responder #(.LINE_IDX_W(8), .DELAY(4)) dut_d4 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]),
    .pmem_resp(resp[0]), .protocol_err(err[0])
  );

  burst_mem_responder #(.LINE_IDX_W(8), .DELAY(0)) dut_d0 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]),
    .pmem_resp(resp[1]), .protocol_err(err[1])
  );

  always #5 clk = ~clk;

  function automatic int unsigned dly(input int unsigned u);
    return (u == 0) ? 4 : 0;
  endfunction

  // One full transaction starting and ending at a negedge in IDLE.
  task automatic txn(input int unsigned u, input bit w, input logic [31:0] a,
                     input logic [255:0] line, input bit drop, input string nm);
    int unsigned  d    = dly(u);
    logic [7:0]   idx  = a[12:5];
    logic [255:0] cur  = model[u][idx];
    bit           have = known[u][idx];
    logic [63:0]  exp_r;
    rd[u] = !w; wr[u] = w; addr[u] = a; wdata[u] = line[63:0];
    @(posedge clk);
    if (drop) errflag[u] = 1'b1;
    for (int unsigned i = 0; i < d; i++) begin
      @(negedge clk);
      if (drop) begin rd[u] = 1'b0; wr[u] = 1'b0; end
      checks++;
      if (resp[u] !== 1'b0) begin
        errors++;
        $display("FAIL %s wait%0d resp got %b want 0", nm, i, resp[u]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (drop) begin rd[u] = 1'b0; wr[u] = 1'b0; end
      if (w) wdata[u] = line[64*k +: 64];
      checks++;
      if (resp[u] !== 1'b1) begin
        errors++;
        $display("FAIL %s beat%0d resp got %b want 1", nm, k, resp[u]);
      end
      exp_r = w ? 64'd0 : cur[64*k +: 64];
      if (w || have) begin
        checks++;
        if (rdata[u] !== exp_r) begin
          errors++;
          $display("FAIL %s beat%0d rdata got %h want %h", nm, k, rdata[u], exp_r);
        end
      end
    end
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0;
    checks++;
    if (resp[u] !== 1'b0 || rdata[u] !== 64'd0 || err[u] !== errflag[u]) begin
      errors++;
      $display("FAIL %s done resp/rdata/err got %b/%h/%b want 0/0/%b",
               nm, resp[u], rdata[u], err[u], errflag[u]);
    end
    @(negedge clk);
    checks++;
    if (resp[u] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle resp got %b want 0", nm, resp[u]);
    end
    if (w) begin
      model[u][idx] = line;
      known[u][idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int unsigned u = 0; u < 2; u++) begin
      checks++;
      if (resp[u] !== 1'b0 || rdata[u] !== 64'd0 || err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d resp/rdata/err got %b/%h/%b want 0/0/0",
                 u, resp[u], rdata[u], err[u]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_delay();
    txn(0, 1'b1, 32'h0000_0040, {64'hDDDD_0003, 64'hCCCC_0002, 64'hBBBB_0001, 64'hAAAA_0000}, 1'b0, "preload40");
    txn(0, 1'b0, 32'h0000_0040, '0, 1'b0, "read40_d4");
  endtask

  task automatic test_low_bits_ignored();
    txn(0, 1'b1, 32'h0000_0060, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, "write60");
    txn(0, 1'b0, 32'h0000_007F, '0, 1'b0, "read7F");
  endtask

  task automatic test_alias();
    txn(0, 1'b1, 32'h0000_0020, {4{64'h0123_4567_89AB_CDEF}} ^ 256'h5A, 1'b0, "write20");
    txn(0, 1'b0, 32'h0000_2020, '0, 1'b0, "read2020");
  endtask

  task automatic test_back_to_back();
    txn(1, 1'b1, 32'h0000_0100, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b0, "d0_write");
    txn(1, 1'b0, 32'h0000_0100, '0, 1'b0, "d0_read_a");
    txn(1, 1'b0, 32'h0000_0100, '0, 1'b0, "d0_read_b");
  endtask

  task automatic test_drop_request();
    txn(0, 1'b0, 32'h0000_0040, '0, 1'b1, "drop_read");
  endtask

  task automatic test_both_high();
    rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0000_0100;
    errflag[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp[1] !== 1'b0 || err[1] !== 1'b1) begin
        errors++;
        $display("FAIL both_high c%0d resp/err got %b/%b want 0/1", i, resp[1], err[1]);
      end
    end
    rd[1] = 1'b0; wr[1] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err[1] !== 1'b1 || resp[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky resp/err got %b/%b want 0/1", resp[1], err[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [255:0] old_l = {64'h0D, 64'h0C, 64'h0B, 64'h0A};
    logic [255:0] new_l = {64'hE3E3, 64'hE2E2, 64'hE1E1, 64'hE0E0};
    txn(0, 1'b1, 32'h0000_0080, old_l, 1'b0, "rst_old");
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0080; wdata[0] = new_l[63:0];
    @(posedge clk);
    repeat (dly(0)) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wdata[0] = new_l[64*k +: 64];
      checks++;
      if (resp[0] !== 1'b1) begin
        errors++;
        $display("FAIL rst_beat%0d resp got %b want 1", k, resp[0]);
      end
      if (k == 2) reset_n = 1'b0;
    end
    @(negedge clk);
    for (int unsigned u = 0; u < 2; u++) begin
      checks++;
      if (resp[u] !== 1'b0 || rdata[u] !== 64'd0 || err[u] !== 1'b0) begin
        errors++;
        $display("FAIL rst_abort u%0d resp/rdata/err got %b/%h/%b want 0/0/0",
                 u, resp[u], rdata[u], err[u]);
      end
    end
    reset_n = 1'b1; wr[0] = 1'b0;
    errflag[0] = 1'b0; errflag[1] = 1'b0;
    model[0][4] = {old_l[255:128], new_l[127:0]};
    txn(0, 1'b0, 32'h0000_0080, '0, 1'b0, "rst_readback");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int unsigned  u   = $urandom_range(0, 1);
      bit           w   = 1'($urandom_range(0, 1));
      logic [31:0]  a   = $urandom;
      logic [255:0] l;
      a[12:5] = 8'($urandom_range(0, 7));
      for (int j = 0; j < 8; j++) l[32*j +: 32] = $urandom;
      txn(u, w, a, l, 1'b0, w ? "rand_wr" : "rand_rd");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0; errflag[u] = 1'b0;
      for (int unsigned i = 0; i < 256; i++) known[u][i] = 1'b0;
    end
    test_reset();
    test_read_delay();
    test_low_bits_ignored();
    test_alias();
    test_back_to_back();
    test_drop_request();
    test_both_high();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
